// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, branch-select codes, NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_pkg;

  // Fetch FSM state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  // Branch-select field codes, shared with the instruction decoder.
  typedef enum logic [1:0] {
    BS_NEXT = 2'b00,
    BS_COND = 2'b01,
    BS_JMR  = 2'b10,
    BS_BR   = 2'b11
  } bs_t;

  // Instruction word with opcode 0000000: IR contents after reset or flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Word-address increment; wraps FFFFFFFF to 0.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_branch_resolve.sv
// Branch resolution: decides whether the executing instruction redirects fetch.
// Latency: purely combinational.
// Backpressure: none; result is only meaningful while ex_valid is high.
module branch_resolve
  import instruction_fetch_pkg::*;
(
  input  logic        ex_valid,
  input  logic [1:0]  bs,
  input  logic        ps,
  input  logic        z,
  input  logic [31:0] br_target,
  input  logic [31:0] jmp_target,
  output logic        taken,
  output logic [31:0] target
);

  // Taken when a conditional branch meets its zero polarity, or on any jump/branch.
  always_comb begin
    taken = 1'b0;
    if (ex_valid) begin
      case (bs)
        BS_COND: taken = z ^ ps;
        BS_JMR:  taken = 1'b1;
        BS_BR:   taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  // Jump-register uses the bus-A target; the PC-relative forms use the branch target.
  always_comb begin
    target = br_target;
    if (bs == BS_JMR) begin
      target = jmp_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word reads at PC, holds the returned word in IR for the decoder.
// Latency: IR valid on the ACK edge; zero-wait memory and no stall give one instruction per cycle.
// Backpressure: STALL at an ACK edge parks in HOLD with IMEM_REQ low until the consume edge; redirects override STALL.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR_instruction,
  output logic        IR_VALID,
  input  logic        STALL,
  input  logic        EX_VALID,
  input  logic [1:0]  BS,
  input  logic        PS,
  input  logic        Z,
  input  logic [31:0] BR_TARGET,
  input  logic [31:0] JMP_TARGET,
  output logic [31:0] PC_OUT
);
  import instruction_fetch_pkg::*;

  fetch_state_t state;
  logic         req_q;
  logic [31:0]  addr_q;    // address of the request on the bus
  logic [31:0]  pc_q;      // next address to fetch once the bus is free
  logic [31:0]  ir_q;
  logic         ir_vld_q;
  logic [31:0]  pc_out_q;

  logic         taken;
  logic [31:0]  target;
  logic         ack;
  logic         consume;

  branch_resolve u_branch_resolve (
    .ex_valid   (EX_VALID),
    .bs         (BS),
    .ps         (PS),
    .z          (Z),
    .br_target  (BR_TARGET),
    .jmp_target (JMP_TARGET),
    .taken      (taken),
    .target     (target)
  );

  // An ACK only counts while a request is actually outstanding.
  assign ack     = IMEM_ACK & req_q;
  assign consume = ir_vld_q & ~STALL;

  assign IMEM_REQ       = req_q;
  assign IMEM_ADDR      = addr_q;
  assign IR_instruction = ir_q;
  assign IR_VALID       = ir_vld_q;
  assign PC_OUT         = pc_out_q;

  // Fetch FSM with all bus and IR outputs registered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      ir_q     <= NOP_INSTR;
      ir_vld_q <= 1'b0;
      pc_out_q <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
          if (taken) begin
            pc_q   <= target;
            addr_q <= target;
          end else begin
            addr_q <= pc_q;
          end
        end

        FETCH: begin
          if (taken) begin
            // Redirect: squash IR; a request that has not completed must still
            // be waited out at its old address before the target can be issued.
            ir_q     <= NOP_INSTR;
            ir_vld_q <= 1'b0;
            pc_q     <= target;
            if (ack) begin
              addr_q <= target;
            end else begin
              state <= FLUSH;
            end
          end else if (ack) begin
            ir_q     <= IMEM_RDATA;
            pc_out_q <= addr_q;
            ir_vld_q <= 1'b1;
            pc_q     <= pc_incr(addr_q);
            // Keep streaming only if the consumer is taking words this edge.
            if (STALL) begin
              state <= HOLD;
              req_q <= 1'b0;
            end else begin
              addr_q <= pc_incr(addr_q);
            end
          end else if (consume) begin
            ir_vld_q <= 1'b0;
          end
        end

        HOLD: begin
          if (taken) begin
            ir_q     <= NOP_INSTR;
            ir_vld_q <= 1'b0;
            pc_q     <= target;
            addr_q   <= target;
            req_q    <= 1'b1;
            state    <= FETCH;
          end else if (consume) begin
            ir_vld_q <= 1'b0;
            addr_q   <= pc_q;
            req_q    <= 1'b1;
            state    <= FETCH;
          end
        end

        FLUSH: begin
          // Stale request still on the bus; its data is dropped when it returns.
          if (taken) begin
            pc_q <= target;
          end
          if (ack) begin
            addr_q <= taken ? target : pc_q;
            state  <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, which is the PC value loaded at reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000000 (opcode 0000000), which is the IR contents after reset or flush.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port IMEM_REQ, output, 1 bit: instruction memory read request.
REQ-006 SHALL have port IMEM_ADDR, output, 32 bits: word address of the request (equals PC).
REQ-007 SHALL have port IMEM_ACK, input, 1 bit: read data valid; meaningful only while IMEM_REQ=1.
REQ-008 SHALL have port IMEM_RDATA, input, 32 bits: instruction word, sampled when IMEM_ACK=1.
REQ-009 SHALL have port IR_instruction, output, 32 bits: the instruction presented to the decoder.
REQ-010 SHALL have port IR_VALID, output, 1 bit: IR_instruction holds a live instruction.
REQ-011 SHALL have port STALL, input, 1 bit: the consumer cannot accept IR this cycle.
REQ-012 SHALL have port EX_VALID, input, 1 bit: BS/PS/Z/targets belong to a valid executing instruction.
REQ-013 SHALL have port BS, input, 2 bits: branch select (00 next, 01 conditional, 10 jump register, 11 branch).
REQ-014 SHALL have port PS, input, 1 bit: polarity of the zero condition.
REQ-015 SHALL have port Z, input, 1 bit: datapath zero flag.
REQ-016 SHALL have port BR_TARGET, input, 32 bits: PC-relative target, computed externally.
REQ-017 SHALL have port JMP_TARGET, input, 32 bits: register (bus A) target.
REQ-018 SHALL have port PC_OUT, output, 32 bits: address of the instruction currently held in IR.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, HOLD, FLUSH.
REQ-020 IDLE SHALL last exactly one cycle after RESET deasserts, then go to FETCH with IMEM_REQ=1 and IMEM_ADDR=PC.
REQ-021 In FETCH, IMEM_REQ and IMEM_ADDR SHALL stay stable until IMEM_ACK=1; requests are never withdrawn.
REQ-022 On an ACK edge, the block SHALL load IMEM_RDATA into IR, set PC_OUT to PC, set PC to PC+1 (mod 2^32; FFFFFFFF wraps to 0), and set IR_VALID=1.
REQ-023 IR SHALL be consumed on an edge with IR_VALID=1 and STALL=0.
REQ-024 If the consumer does not consume IR on the ACK edge, the FSM SHALL go to HOLD and drop IMEM_REQ.
REQ-025 If the consumer does consume IR on the ACK edge, the FSM SHALL stay in FETCH with the new PC, giving one instruction per cycle with zero-wait memory.
REQ-026 HOLD SHALL keep IR and PC_OUT frozen while STALL=1, and return to FETCH on the consume edge.
REQ-027 Taken SHALL be EX_VALID & ((BS=01 & (Z^PS)) | BS=10 | BS=11); target is BR_TARGET for 01/11 and JMP_TARGET for 10.
REQ-028 On a taken edge, the block SHALL load target into PC, force IR_VALID=0 and IR=NOP_INSTR, and override STALL.
REQ-029 On a taken edge with a request outstanding and no ACK, the FSM SHALL go to FLUSH, holding the old address until ACK.
REQ-030 In FLUSH, ACK data SHALL be discarded, and the FSM SHALL go to FETCH at the target on the next cycle.
REQ-031 If taken and ACK occur on the same edge, the returned data SHALL be discarded and the next request SHALL use the target.
REQ-032 A taken redirect during HOLD or IDLE SHALL go directly to FETCH at the target.
REQ-033 IMEM_ACK while IMEM_REQ=0 SHALL be ignored.

Reset
REQ-034 While RESET=0, outputs SHALL be asynchronously forced to IMEM_REQ=0, IMEM_ADDR=RESET_PC, IR=NOP_INSTR, IR_VALID=0, PC_OUT=RESET_PC, and state SHALL be IDLE.
REQ-035 Reset mid-fetch SHALL abandon the outstanding request; an ACK arriving during or after reset SHALL not load IR.

Structure
REQ-036 FSM state encoding, BS codes (BS_NEXT, BS_COND, BS_JMR, BS_BR) and NOP_INSTR SHALL live in a shared package used with the instruction decoder.
REQ-037 SHALL contain one sub-module, branch_resolve: combinational taken/target logic per REQ-027.

Verification
REQ-038 Release reset, zero-wait ACK, STALL=0 -> addresses 0,1,2,3 on consecutive cycles; IR_VALID high from cycle 2.
REQ-039 STALL=1 for 3 cycles with IR=32'h04000000 -> IR frozen, IMEM_REQ=0, PC_OUT constant; fetch resumes the cycle after release.
REQ-040 BS=01, PS=0, Z=1, BR_TARGET=32'h40, fetch outstanding with ACK delayed 2 cycles -> stale data discarded, next IMEM_ADDR=32'h40, IR_VALID=0 until the target returns.
REQ-041 BS=01, PS=1, Z=1 -> not taken, sequential fetch; BS=10 with JMP_TARGET=32'h100 during STALL -> redirect to 32'h100.
REQ-042 PC=32'hFFFFFFFF acked -> next IMEM_ADDR=32'h00000000.
REQ-043 RESET low while IMEM_REQ=1, then ACK pulse -> IMEM_REQ=0 immediately, IR=NOP_INSTR, first post-reset address=RESET_PC.
